// File: rtl/alu_exec_ctrl_pkg.sv
// Shared encodings for the ALU execution controller: opcodes, condition codes,
// flag bit positions, controller states and small decode helpers.
package alu_exec_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_ADC  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_MOVN = 4'b0110,
        OP_MOV  = 4'b0111,
        OP_LSL  = 4'b1000,
        OP_LSR  = 4'b1001,
        OP_ASR  = 4'b1010,
        OP_CMP  = 4'b1011,
        OP_NOP0 = 4'b1100,
        OP_NOP1 = 4'b1101,
        OP_NOP2 = 4'b1110,
        OP_NOP3 = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_EQ = 2'b01,
        COND_MI = 2'b10,
        COND_CS = 2'b11
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_EX   = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    // True when the condition field allows execution given the current flags.
    function automatic logic cond_pass(input logic [1:0] cond, input logic [3:0] f);
        logic pass;
        case (cond_e'(cond))
            COND_AL: pass = 1'b1;
            COND_EQ: pass = f[FLAG_Z];
            COND_MI: pass = f[FLAG_N];
            default: pass = f[FLAG_C];
        endcase
        return pass;
    endfunction

    // Everything from ADD up to ASR writes its result back to Rd.
    function automatic logic op_writes_reg(input logic [3:0] op);
        return op <= OP_ASR;
    endfunction

    // Only the add/subtract group and CMP update the architectural flags.
    function automatic logic op_writes_flags(input logic [3:0] op);
        return (op <= OP_SUB) || (op == OP_CMP);
    endfunction

    // The top four encodings are reserved as no-operations.
    function automatic logic op_is_nop(input logic [3:0] op);
        return op >= OP_NOP0;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREG x DATA_W storage with two registered read ports that
// double as the ALU operand registers, one write port and a combinational
// debug read port.
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [2:0]        rd_a_addr,
    input  logic [2:0]        rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              we,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;

    // Next register contents: full-width write of one entry when enabled.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Read ports capture the pre-write contents, so Rd == Rs sees one value.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (rd_en) begin
            rd_a_d = regs_q[rd_a_addr];
            rd_b_d = regs_q[rd_b_addr];
        end
    end

    // Storage and operand registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execution controller: fetches one instruction at a time, reads operands,
// presents them to an external ALU and retires the result with condition
// and opcode-dependent write-back.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [6:0]        alu_ldsh,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              done,
    output logic              skipped,
    output logic [3:0]        flags,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [3:0]        op_q, op_d;
    logic [6:0]        ldsh_q, ldsh_d;
    logic              cond_ok_q, cond_ok_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        res_flags_q, res_flags_d;
    logic [3:0]        flags_q, flags_d;
    logic              rf_we;
    logic              flag_we;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only the hand-off out of IDLE waits on the requester.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid && instr_ready) state_d = ST_RD;
            ST_RD:   state_d = ST_EX;
            ST_EX:   state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from state and the latched instruction.
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        done        = (state_q == ST_WB);
        skipped     = (state_q == ST_WB) && (!cond_ok_q || op_is_nop(op_q));
        rf_we       = (state_q == ST_WB) && cond_ok_q && op_writes_reg(op_q);
        flag_we     = (state_q == ST_WB) && cond_ok_q && op_writes_flags(op_q);
    end

    // Datapath captures: instruction in IDLE, decode in RD, ALU outputs in EX.
    always_comb begin
        instr_d     = instr_q;
        op_d        = op_q;
        ldsh_d      = ldsh_q;
        cond_ok_d   = cond_ok_q;
        result_d    = result_q;
        res_flags_d = res_flags_q;
        flags_d     = flags_q;
        if (state_q == ST_IDLE && instr_valid) begin
            instr_d = instr;
        end
        if (state_q == ST_RD) begin
            op_d      = instr_q[13:10];
            ldsh_d    = instr_q[6:0];
            cond_ok_d = cond_pass(instr_q[15:14], flags_q);
        end
        if (state_q == ST_EX) begin
            result_d    = alu_result;
            res_flags_d = alu_flags;
        end
        if (flag_we) begin
            flags_d = res_flags_q;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q     <= '0;
            op_q        <= '0;
            ldsh_q      <= '0;
            cond_ok_q   <= 1'b0;
            result_q    <= '0;
            res_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            instr_q     <= instr_d;
            op_q        <= op_d;
            ldsh_q      <= ldsh_d;
            cond_ok_q   <= cond_ok_d;
            result_q    <= result_d;
            res_flags_q <= res_flags_d;
            flags_q     <= flags_d;
        end
    end

    alu_regfile #(
        .DATA_W(DATA_W),
        .NREG  (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (state_q == ST_RD),
        .rd_a_addr(instr_q[9:7]),
        .rd_b_addr(instr_q[6:4]),
        .rd_a_data(alu_a),
        .rd_b_data(alu_b),
        .we       (rf_we),
        .wr_addr  (instr_q[9:7]),
        .wr_data  (result_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign alu_op   = op_q;
    assign alu_ldsh = ldsh_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed, scoreboard-driven bench for alu_exec_ctrl; the bench plays the
// role of the external ALU by presenting a chosen result/flags per instruction.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [6:0]  alu_ldsh;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic        done;
    logic        skipped;
    logic [3:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] old_val;
        logic [15:0] new_val;
        logic [3:0]  flags;
        logic        skipped;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [6:0]  ldsh;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_regs [8];
    logic [3:0]  m_flags;
    int          n_checks = 0;
    int          n_errors = 0;

    alu_exec_ctrl #(.DATA_W(16), .NREG(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ldsh   (alu_ldsh),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .done       (done),
        .skipped    (skipped),
        .flags      (flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the retirement, push it, and hand the instruction over.
    task automatic applyStimulus(input logic [1:0] c, input logic [3:0] op, input logic [2:0] rd,
                                 input logic [6:0] ldsh, input logic [15:0] res, input logic [3:0] af);
        exp_t e;
        logic pass;
        int   guard;
        case (c)
            2'b00:   pass = 1'b1;
            2'b01:   pass = m_flags[2];
            2'b10:   pass = m_flags[3];
            default: pass = m_flags[1];
        endcase
        e.rd      = rd;
        e.a       = m_regs[rd];
        e.b       = m_regs[ldsh[6:4]];
        e.op      = op;
        e.ldsh    = ldsh;
        e.old_val = m_regs[rd];
        e.skipped = !pass || (op >= 4'd12);
        if (pass && op <= 4'd10) m_regs[rd] = res;
        if (pass && (op <= 4'd2 || op == 4'd11)) m_flags = af;
        e.new_val = m_regs[rd];
        e.flags   = m_flags;
        sb.push_back(e);
        @(negedge clk);
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", 16'(instr_ready), 16'd1);
        instr       = {c, op, rd, ldsh};
        instr_valid = 1'b1;
        alu_result  = res;
        alu_flags   = af;
        dbg_addr    = rd;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
    endtask

    // Pop the prediction and follow the instruction to retirement.
    task automatic checkOutput();
        exp_t        e;
        int          cyc;
        logic [15:0] cap_a, cap_b;
        logic [3:0]  cap_op;
        logic [6:0]  cap_ldsh;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
            return;
        end
        e        = sb.pop_front();
        cap_a    = 'x;
        cap_b    = 'x;
        cap_op   = 'x;
        cap_ldsh = 'x;
        cyc      = 1;
        check("ready_low_in_rd", 16'(instr_ready), 16'd0);
        while (done !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                cap_a    = alu_a;
                cap_b    = alu_b;
                cap_op   = alu_op;
                cap_ldsh = alu_ldsh;
            end
        end
        check("done_latency", 16'(cyc), 16'd3);
        check("alu_a", cap_a, e.a);
        check("alu_b", cap_b, e.b);
        check("alu_op", 16'(cap_op), 16'(e.op));
        check("alu_ldsh", 16'(cap_ldsh), 16'(e.ldsh));
        check("skipped", 16'(skipped), 16'(e.skipped));
        check("dbg_prewrite", dbg_data, e.old_val);
        @(negedge clk);
        check("done_single_pulse", 16'(done), 16'd0);
        check("dbg_postwrite", dbg_data, e.new_val);
        check("flags", 16'(flags), 16'(e.flags));
        check("ready_after_wb", 16'(instr_ready), 16'd1);
    endtask

    initial begin
        int          acc_pat;
        int          done_pat;
        int          dones;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        alu_result  = '0;
        alu_flags   = '0;
        dbg_addr    = '0;
        m_flags     = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check("reset_reg", dbg_data, 16'd0);
        end
        check("reset_flags", 16'(flags), 16'd0);
        check("reset_ready", 16'(instr_ready), 16'd1);
        check("reset_done", 16'(done), 16'd0);
        check("reset_alu_a", alu_a, 16'd0);
        check("reset_alu_op", 16'(alu_op), 16'd0);

        // MOV_n R1,#100: writes R1, flags untouched despite ALU flags.
        applyStimulus(2'b00, 4'b0110, 3'd1, 7'd100, 16'd100, 4'b1010);
        checkOutput();
        // Load R1=5, R2=5.
        applyStimulus(2'b00, 4'b0110, 3'd1, 7'd5, 16'd5, 4'b0000);
        checkOutput();
        applyStimulus(2'b00, 4'b0110, 3'd2, 7'd5, 16'd5, 4'b0000);
        checkOutput();
        // SUB R1,R2 with Z from the ALU.
        applyStimulus(2'b00, 4'b0010, 3'd1, {3'd2, 4'd0}, 16'd0, 4'b0100);
        checkOutput();
        // ADD R1,R2 under Cond EQ: executes because Z=1.
        applyStimulus(2'b01, 4'b0000, 3'd1, {3'd2, 4'd0}, 16'd5, 4'b0000);
        checkOutput();
        // Cond MI with N=0: skipped, R3 unchanged.
        applyStimulus(2'b10, 4'b0110, 3'd3, 7'd7, 16'd7, 4'b0000);
        checkOutput();
        // CMP: flags only.
        applyStimulus(2'b00, 4'b1011, 3'd1, {3'd2, 4'd0}, 16'hBEEF, 4'b1001);
        checkOutput();
        // NOP: skipped even though the condition passes.
        applyStimulus(2'b00, 4'b1100, 3'd1, {3'd2, 4'd0}, 16'h1111, 4'b0110);
        checkOutput();
        // Cond CS with C=0: skipped; Rd == Rs reads one value on both ports.
        applyStimulus(2'b11, 4'b0101, 3'd2, {3'd2, 4'd0}, 16'h0000, 4'b0000);
        checkOutput();
        // Cond MI with N=1: executes, Rd == Rs again.
        applyStimulus(2'b10, 4'b0011, 3'd2, {3'd2, 4'd0}, 16'h00A5, 4'b0000);
        checkOutput();

        // Back-to-back issue with instr_valid held high.
        @(negedge clk);
        instr       = {2'b00, 4'b0110, 3'd5, 7'd0};
        alu_result  = 16'h1234;
        alu_flags   = 4'b0000;
        instr_valid = 1'b1;
        acc_pat     = 0;
        done_pat    = 0;
        for (int i = 0; i < 16; i++) begin
            if (instr_ready === 1'b1) acc_pat = acc_pat | (1 << i);
            if (done === 1'b1) done_pat = done_pat | (1 << i);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        m_regs[5]   = 16'h1234;
        check("throughput_accept_pattern", 16'(acc_pat), 16'h1111);
        check("throughput_done_pattern", 16'(done_pat), 16'h8888);
        dbg_addr = 3'd5;
        #1;
        check("throughput_r5", dbg_data, m_regs[5]);

        // Reset during EX of ADD R4,R5: aborted with no retirement.
        @(negedge clk);
        instr       = {2'b00, 4'b0000, 3'd4, 3'd5, 4'd0};
        alu_result  = 16'h7777;
        alu_flags   = 4'b1111;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_in_ex_alu_op", 16'(alu_op), 16'd0);
        rst = 1'b1;
        #1;
        check("abort_done_low", 16'(done), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flags = '0;
        dones   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 16'(dones), 16'd0);
        dbg_addr = 3'd4;
        #1;
        check("abort_r4", dbg_data, m_regs[4]);
        dbg_addr = 3'd5;
        #1;
        check("abort_r5_cleared", dbg_data, m_regs[5]);
        check("abort_flags", 16'(flags), 16'(m_flags));
        check("abort_ready", 16'(instr_ready), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
